// File: rtl/muldiv_hilo_unit_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
// The master drives the operation request; the slave owns HI/LO and status.
interface muldiv_hilo_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] BusA;
  logic [WIDTH-1:0] BusB;
  logic             WrHi;
  logic             WrLo;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, BusA, BusB, WrHi, WrLo,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Op, BusA, BusB, WrHi, WrLo,
    output Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Signed ops run on magnitudes; the sign fix-up is applied when HI/LO are written.
module muldiv_hilo_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic                 CLK,
  input logic                 Reset_L,
  muldiv_hilo_unit_if.slave   bus_io
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    signed_op = ~bus_io.Op[0];
    a_mag = (signed_op && bus_io.BusA[WIDTH-1]) ? -bus_io.BusA : bus_io.BusA;
    b_mag = (signed_op && bus_io.BusB[WIDTH-1]) ? -bus_io.BusB : bus_io.BusB;

    // Multiply: add multiplicand into the high half when the current LSB is set,
    // then shift the whole {carry, hi, lo} right by one.
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

    // Divide: partial remainder shifts in the next dividend bit from acc_lo MSB.
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = div_shift >= {1'b0, opnd_q};

    prod = {acc_hi_q, acc_lo_q};
    if (neg_res_q) prod = -prod;
    quot = neg_res_q ? -acc_lo_q : acc_lo_q;
    if (div0_q) quot = '1;
    rem  = neg_rem_q ? -acc_hi_q : acc_hi_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.Start) begin
          is_div_d  = bus_io.Op[1];
          neg_res_d = signed_op & (bus_io.BusA[WIDTH-1] ^ bus_io.BusB[WIDTH-1]);
          neg_rem_d = signed_op & bus_io.BusA[WIDTH-1];
          div0_d    = bus_io.Op[1] & (bus_io.BusB == '0);
          opnd_d    = b_mag;
          acc_lo_d  = a_mag;
          acc_hi_d  = '0;
          cnt_d     = '0;
          state_d   = StCalc;
        end else begin
          if (bus_io.WrHi) hi_d = bus_io.BusA;
          if (bus_io.WrLo) lo_d = bus_io.BusA;
        end
      end
      StCalc: begin
        if (is_div_q) begin
          acc_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = rem;
          lo_d = quot;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus_io.Busy = (state_q != StIdle);
  assign bus_io.Done = done_q;
  assign bus_io.Hi   = hi_q;
  assign bus_io.Lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed-vector bench for muldiv_hilo_unit: expected {HI,LO} results are queued
// at issue and popped by a monitor whenever the unit pulses Done.
module tb_muldiv_hilo_unit;

  logic CLK = 1'b0;
  logic Reset_L;
  always #5 CLK = ~CLK;

  muldiv_hilo_unit_if #(.WIDTH(32)) bus ();

  muldiv_hilo_unit #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .bus_io  (bus)
  );

  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [31:0] hi_m, lo_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (bus.Done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_unexpected: got Hi=%h Lo=%h, expected no Done", bus.Hi, bus.Lo);
      end else begin
        check("result", {bus.Hi, bus.Lo}, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input bit wrhi_start, input bit wrhi_mid);
    int busy_n = 0;
    int d0;
    @(posedge CLK); #1;
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.BusA  = a;
    bus.BusB  = b;
    bus.WrHi  = wrhi_start;
    exp_q.push_back(exp);
    d0 = done_cnt;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    bus.WrHi  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.Busy !== 1'b1) break;
      busy_n++;
      if (i == 0) check({name, "_hilo_hold"}, {bus.Hi, bus.Lo}, {hi_m, lo_m});
      if (wrhi_mid && i == 5) begin
        bus.WrHi = 1'b1;
        bus.BusA = 32'h0000_AAAA;
      end
      if (wrhi_mid && i == 6) begin
        bus.WrHi  = 1'b0;
        check({name, "_mthi_ignored"}, {bus.Hi, bus.Lo}, {hi_m, lo_m});
        bus.Start = 1'b1;
        bus.Op    = 2'b01;
      end
      if (wrhi_mid && i == 7) bus.Start = 1'b0;
    end
    check({name, "_busy_cycles"}, 64'(busy_n), 64'd33);
    @(posedge CLK); #1;
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_idle_after"}, {63'd0, bus.Busy}, 64'd0);
    hi_m = exp[63:32];
    lo_m = exp[31:0];
  endtask

  initial begin
    int d0;
    Reset_L   = 1'b0;
    bus.Start = 1'b0;
    bus.Op    = 2'b00;
    bus.BusA  = '0;
    bus.BusB  = '0;
    bus.WrHi  = 1'b0;
    bus.WrLo  = 1'b0;
    hi_m = '0;
    lo_m = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_hilo", {bus.Hi, bus.Lo}, 64'd0);
    check("reset_busy_done", {62'd0, bus.Busy, bus.Done}, 64'd0);
    Reset_L = 1'b1;

    run_op("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 0);
    run_op("mult_neg",   2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 0, 0);
    run_op("div_neg",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0);
    run_op("divu_wrhi",  2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 1, 0);
    run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 0);
    run_op("div_negb",   2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0, 0);
    run_op("mult_min",   2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 0);
    run_op("divu_zero",  2'b11, 32'h0000_1234, 32'h0000_0000, 64'h0000_1234_FFFF_FFFF, 0, 1);
    run_op("div_zero",   2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF, 0, 0);

    // MTLO in idle, then MTHI and MTLO together.
    @(posedge CLK); #1;
    bus.WrLo = 1'b1;
    bus.BusA = 32'h0000_0055;
    @(posedge CLK); #1;
    bus.WrLo = 1'b0;
    lo_m = 32'h0000_0055;
    check("mtlo_idle", {bus.Hi, bus.Lo}, {hi_m, lo_m});
    bus.WrHi = 1'b1;
    bus.WrLo = 1'b1;
    bus.BusA = 32'hCAFE_F00D;
    @(posedge CLK); #1;
    bus.WrHi = 1'b0;
    bus.WrLo = 1'b0;
    hi_m = 32'hCAFE_F00D;
    lo_m = 32'hCAFE_F00D;
    check("mthi_mtlo_both", {bus.Hi, bus.Lo}, {hi_m, lo_m});

    // Asynchronous reset in the middle of a divide: no result, no Done.
    bus.Start = 1'b1;
    bus.Op    = 2'b10;
    bus.BusA  = 32'd100;
    bus.BusB  = 32'd7;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    d0 = done_cnt;
    Reset_L = 1'b0;
    #1;
    check("midop_reset_hilo", {bus.Hi, bus.Lo}, 64'd0);
    check("midop_reset_busy_done", {62'd0, bus.Busy, bus.Done}, 64'd0);
    @(posedge CLK); #1;
    Reset_L = 1'b1;
    hi_m = '0;
    lo_m = '0;
    repeat (40) @(posedge CLK);
    #1;
    check("midop_reset_no_done", 64'(done_cnt), 64'(d0));
    check("midop_reset_hilo_after", {bus.Hi, bus.Lo}, 64'd0);

    run_op("multu_after_reset", 2'b01, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
